// File: rtl/display_scanner.sv
// display_scanner
//   Picks one of N_SRC packed sources (manual select or timed auto-rotation),
//   captures it once per scan frame so a frame never mixes two values, and
//   time-multiplexes it as hex onto N_DIGITS active-low 7-segment digits.
// Ports
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_src_bus  N_SRC sources, source k at [k*W +: W], W = 4*N_DIGITS
//   i_sel      manual source select
//   i_auto     1 = rotate sources every ROTATE_FRAMES frames
//   i_hold     1 = freeze snapshot and rotation (scanning continues)
//   i_lzb      1 = blank leading zero digits
//   o_seg      {dp,g,f,e,d,c,b,a}, active-low
//   o_an       digit enables, active-low one-hot
//   o_cur_src  source currently displayed
module display_scanner #(
    parameter int N_SRC         = 6,
    parameter int N_DIGITS      = 8,
    parameter int SCAN_DIV      = 4,
    parameter int ROTATE_FRAMES = 64
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [N_SRC*4*N_DIGITS-1:0]     i_src_bus,
    input  logic [$clog2(N_SRC)-1:0]        i_sel,
    input  logic                            i_auto,
    input  logic                            i_hold,
    input  logic                            i_lzb,
    output logic [7:0]                      o_seg,
    output logic [N_DIGITS-1:0]             o_an,
    output logic [$clog2(N_SRC)-1:0]        o_cur_src
);

    localparam int W     = 4 * N_DIGITS;
    localparam int SEL_W = $clog2(N_SRC);
    localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SCN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W = (ROTATE_FRAMES > 1) ? $clog2(ROTATE_FRAMES) : 1;
    localparam logic [SEL_W:0] LP_NSRC = (SEL_W + 1)'(N_SRC);

    logic [SCN_W-1:0]    r_scan_cnt;
    logic [DIG_W-1:0]    r_dig;
    logic [FRM_W-1:0]    r_frame_cnt;
    logic [SEL_W-1:0]    r_cur_src;
    logic [W-1:0]        r_snap;
    logic                r_blank_all;
    logic [7:0]          r_seg;
    logic [N_DIGITS-1:0] r_an;

    logic                w_tick;
    logic                w_last_dig;
    logic                w_frame_end;
    logic [SEL_W-1:0]    w_nxt_src;
    logic [FRM_W-1:0]    w_nxt_frame;
    logic                w_nxt_blank;
    logic [W-1:0]        w_nxt_snap;
    logic [3:0]          w_nib;
    logic                w_upper_zero;
    logic [7:0]          w_seg;
    logic [N_DIGITS-1:0] w_an;

    assign w_tick      = (r_scan_cnt == SCN_W'(SCAN_DIV - 1));
    assign w_last_dig  = (r_dig == DIG_W'(N_DIGITS - 1));
    assign w_frame_end = w_tick && w_last_dig;

    // Source selection result that would take effect at this frame boundary.
    always_comb begin
        w_nxt_src   = r_cur_src;
        w_nxt_frame = r_frame_cnt;
        w_nxt_blank = r_blank_all;
        if (!i_auto) begin
            w_nxt_frame = '0;
            if ({1'b0, i_sel} >= LP_NSRC) begin
                w_nxt_blank = 1'b1;
            end else begin
                w_nxt_src   = i_sel;
                w_nxt_blank = 1'b0;
            end
        end else begin
            w_nxt_blank = 1'b0;
            if (r_frame_cnt == FRM_W'(ROTATE_FRAMES - 1)) begin
                w_nxt_frame = '0;
                w_nxt_src   = (r_cur_src == SEL_W'(N_SRC - 1)) ? '0 : r_cur_src + 1'b1;
            end else begin
                w_nxt_frame = r_frame_cnt + 1'b1;
            end
        end
    end

    // Snapshot reads the source chosen on this same edge, not the old one.
    always_comb begin
        w_nxt_snap = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (w_nxt_src == SEL_W'(k)) begin
                w_nxt_snap = i_src_bus[k*W +: W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scan_cnt  <= '0;
            r_dig       <= '0;
            r_frame_cnt <= '0;
            r_cur_src   <= '0;
            r_snap      <= '0;
            r_blank_all <= 1'b0;
        end else begin
            r_scan_cnt <= w_tick ? '0 : r_scan_cnt + 1'b1;
            if (w_tick) begin
                r_dig <= w_last_dig ? '0 : r_dig + 1'b1;
            end
            if (w_frame_end && !i_hold) begin
                r_frame_cnt <= w_nxt_frame;
                r_cur_src   <= w_nxt_src;
                r_blank_all <= w_nxt_blank;
                r_snap      <= w_nxt_snap;
            end
        end
    end

    assign w_nib        = r_snap[{r_dig, 2'b00} +: 4];
    assign w_upper_zero = ((r_snap >> {r_dig, 2'b00}) == '0);

    always_comb begin
        w_an        = '1;
        w_an[r_dig] = 1'b0;
    end

    always_comb begin
        w_seg = 8'hFF;
        case (w_nib)
            4'h0: w_seg = 8'hC0;
            4'h1: w_seg = 8'hF9;
            4'h2: w_seg = 8'hA4;
            4'h3: w_seg = 8'hB0;
            4'h4: w_seg = 8'h99;
            4'h5: w_seg = 8'h92;
            4'h6: w_seg = 8'h82;
            4'h7: w_seg = 8'hF8;
            4'h8: w_seg = 8'h80;
            4'h9: w_seg = 8'h90;
            4'hA: w_seg = 8'h88;
            4'hB: w_seg = 8'h83;
            4'hC: w_seg = 8'hC6;
            4'hD: w_seg = 8'hA1;
            4'hE: w_seg = 8'h86;
            default: w_seg = 8'h8E;
        endcase
        // dp marks a frozen display, on the least significant digit only
        if (r_dig == '0 && i_hold) begin
            w_seg[7] = 1'b0;
        end
        if (i_lzb && r_dig != '0 && w_upper_zero) begin
            w_seg[6:0] = 7'h7F;
        end
        if (r_blank_all) begin
            w_seg = 8'hFF;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg <= 8'hFF;
            r_an  <= '1;
        end else begin
            r_seg <= w_seg;
            r_an  <= w_an;
        end
    end

    assign o_seg     = r_seg;
    assign o_an      = r_an;
    assign o_cur_src = r_cur_src;

endmodule
